// File: rtl/tetris_input_ctrl_if.sv
// Player-input bundle between the raw button/ADC sources and tetris_input_ctrl,
// carrying the conditioned command pulses back toward tetris_grid.
interface tetris_input_ctrl_if;
  logic        s1_n;
  logic        s2_n;
  logic [11:0] adc_value;
  logic        game_over;
  logic        move_left;
  logic        move_right;
  logic        move_down;
  logic        rotate;
  logic        tilt_active;

  modport master (
    output s1_n, s2_n, adc_value, game_over,
    input  move_left, move_right, move_down, rotate, tilt_active
  );

  modport slave (
    input  s1_n, s2_n, adc_value, game_over,
    output move_left, move_right, move_down, rotate, tilt_active
  );
endinterface

// File: rtl/tetris_input_ctrl.sv
// Button debounce, joystick tilt hysteresis and DAS/ARR auto-repeat for tetris_grid.
// Optional gravity ticks on move_down are enabled by defining TETRIS_GRAVITY_EN.
module tetris_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DAS_CYCLES      = 12500000,
  parameter int ARR_CYCLES      = 2500000,
  parameter int ADC_RIGHT_ON    = 1820,
  parameter int ADC_RIGHT_OFF   = 1780,
  parameter int ADC_LEFT_ON     = 1480,
  parameter int ADC_LEFT_OFF    = 1520,
  parameter int GRAVITY_CYCLES  = 25000000
) (
  input  logic               clk,
  input  logic               reset,
  tetris_input_ctrl_if.slave io
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0]     DAS_LAST  = 24'(DAS_CYCLES - 1);
  localparam logic [23:0]     ARR_LAST  = 24'(ARR_CYCLES - 1);
  localparam logic [11:0]     RIGHT_ON  = 12'(ADC_RIGHT_ON);
  localparam logic [11:0]     RIGHT_OFF = 12'(ADC_RIGHT_OFF);
  localparam logic [11:0]     LEFT_ON   = 12'(ADC_LEFT_ON);
  localparam logic [11:0]     LEFT_OFF  = 12'(ADC_LEFT_OFF);

  typedef enum logic [1:0] {
    TILT_CENTER = 2'd0,
    TILT_LEFT   = 2'd1,
    TILT_RIGHT  = 2'd2
  } tilt_t;

  typedef enum logic [1:0] {
    RPT_IDLE = 2'd0,
    RPT_DAS  = 2'd1,
    RPT_ARR  = 2'd2
  } rpt_t;

  // Bit 0 is S1 (rotate), bit 1 is S2 (soft drop); all held as 1 = pressed.
  logic [1:0]      meta_r;
  logic [1:0]      sync_r;
  logic [1:0]      pressed_r;
  logic [DB_W-1:0] db_cnt_r [2];
  logic            rot_prev_r;

  logic [11:0] adc_r;
  tilt_t       tilt_r;
  logic        tilt_active_r;

  rpt_t        h_state_r;
  logic [23:0] h_cnt_r;
  logic        h_dir_r;
  rpt_t        s_state_r;
  logic [23:0] s_cnt_r;

  logic move_left_r;
  logic move_right_r;
  logic move_down_r;
  logic rotate_r;

  logic h_active_s;
  logic h_right_s;
  logic h_fire_s;
  logic s_active_s;
  logic s_fire_s;
  logic grav_tick_s;

  // Two-flop synchronizer followed by a per-button stability counter
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r    <= 2'b00;
      sync_r    <= 2'b00;
      pressed_r <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        db_cnt_r[i] <= {DB_W{1'b0}};
      end
    end else begin
      meta_r <= ~{io.s2_n, io.s1_n};
      sync_r <= meta_r;
      for (int i = 0; i < 2; i++) begin
        if (sync_r[i] == pressed_r[i]) begin
          db_cnt_r[i] <= {DB_W{1'b0}};
        end else if (db_cnt_r[i] == DB_LAST) begin
          pressed_r[i] <= sync_r[i];
          db_cnt_r[i]  <= {DB_W{1'b0}};
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + {{(DB_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // Tilt FSM on the registered ADC sample; exact threshold values never transition
  always_ff @(posedge clk) begin
    if (reset) begin
      adc_r         <= 12'd0;
      tilt_r        <= TILT_CENTER;
      tilt_active_r <= 1'b0;
    end else begin
      adc_r         <= io.adc_value;
      tilt_active_r <= (tilt_r != TILT_CENTER);
      case (tilt_r)
        TILT_CENTER: begin
          if (adc_r > RIGHT_ON)      tilt_r <= TILT_RIGHT;
          else if (adc_r < LEFT_ON)  tilt_r <= TILT_LEFT;
          else                       tilt_r <= TILT_CENTER;
        end
        TILT_RIGHT: begin
          if (adc_r < LEFT_ON)        tilt_r <= TILT_LEFT;
          else if (adc_r < RIGHT_OFF) tilt_r <= TILT_CENTER;
          else                        tilt_r <= TILT_RIGHT;
        end
        TILT_LEFT: begin
          if (adc_r > RIGHT_ON)      tilt_r <= TILT_RIGHT;
          else if (adc_r > LEFT_OFF) tilt_r <= TILT_CENTER;
          else                       tilt_r <= TILT_LEFT;
        end
        default: tilt_r <= TILT_CENTER;
      endcase
    end
  end

  // game_over holds both engines idle, so releasing it re-enters DAS with a fresh pulse.
  assign h_active_s = (tilt_r != TILT_CENTER) && !io.game_over;
  assign h_right_s  = (tilt_r == TILT_RIGHT);
  assign h_fire_s   = h_active_s &&
                      ((h_state_r == RPT_IDLE) || (h_dir_r != h_right_s) ||
                       ((h_state_r == RPT_DAS) && (h_cnt_r == DAS_LAST)) ||
                       ((h_state_r == RPT_ARR) && (h_cnt_r == ARR_LAST)));
  assign s_active_s = pressed_r[1] && !io.game_over;
  assign s_fire_s   = s_active_s &&
                      ((s_state_r == RPT_IDLE) ||
                       ((s_state_r == RPT_DAS) && (s_cnt_r == DAS_LAST)) ||
                       ((s_state_r == RPT_ARR) && (s_cnt_r == ARR_LAST)));

  // Horizontal repeat engine; a direction reversal restarts DAS
  always_ff @(posedge clk) begin
    if (reset) begin
      h_state_r    <= RPT_IDLE;
      h_cnt_r      <= 24'd0;
      h_dir_r      <= 1'b0;
      move_left_r  <= 1'b0;
      move_right_r <= 1'b0;
    end else begin
      move_right_r <= h_fire_s && h_right_s;
      move_left_r  <= h_fire_s && !h_right_s;
      if (!h_active_s) begin
        h_state_r <= RPT_IDLE;
        h_cnt_r   <= 24'd0;
      end else if ((h_state_r == RPT_IDLE) || (h_dir_r != h_right_s)) begin
        h_state_r <= RPT_DAS;
        h_cnt_r   <= 24'd0;
        h_dir_r   <= h_right_s;
      end else begin
        case (h_state_r)
          RPT_DAS: begin
            if (h_cnt_r == DAS_LAST) begin
              h_state_r <= RPT_ARR;
              h_cnt_r   <= 24'd0;
            end else begin
              h_cnt_r <= h_cnt_r + 24'd1;
            end
          end
          RPT_ARR: begin
            if (h_cnt_r == ARR_LAST) h_cnt_r <= 24'd0;
            else                     h_cnt_r <= h_cnt_r + 24'd1;
          end
          default: begin
            h_state_r <= RPT_IDLE;
            h_cnt_r   <= 24'd0;
          end
        endcase
      end
    end
  end

  // Soft-drop repeat engine driven by the debounced S2 level
  always_ff @(posedge clk) begin
    if (reset) begin
      s_state_r <= RPT_IDLE;
      s_cnt_r   <= 24'd0;
    end else if (!s_active_s) begin
      s_state_r <= RPT_IDLE;
      s_cnt_r   <= 24'd0;
    end else begin
      case (s_state_r)
        RPT_IDLE: begin
          s_state_r <= RPT_DAS;
          s_cnt_r   <= 24'd0;
        end
        RPT_DAS: begin
          if (s_cnt_r == DAS_LAST) begin
            s_state_r <= RPT_ARR;
            s_cnt_r   <= 24'd0;
          end else begin
            s_cnt_r <= s_cnt_r + 24'd1;
          end
        end
        RPT_ARR: begin
          if (s_cnt_r == ARR_LAST) s_cnt_r <= 24'd0;
          else                     s_cnt_r <= s_cnt_r + 24'd1;
        end
        default: begin
          s_state_r <= RPT_IDLE;
          s_cnt_r   <= 24'd0;
        end
      endcase
    end
  end

`ifdef TETRIS_GRAVITY_EN
  localparam int GR_W = (GRAVITY_CYCLES > 2) ? $clog2(GRAVITY_CYCLES) : 1;
  localparam logic [GR_W-1:0] GR_LAST = GR_W'(GRAVITY_CYCLES - 1);

  logic [GR_W-1:0] grav_cnt_r;

  assign grav_tick_s = (grav_cnt_r == GR_LAST) && !io.game_over;

  // Free-running gravity period counter, parked at zero during game_over
  always_ff @(posedge clk) begin
    if (reset || io.game_over) begin
      grav_cnt_r <= {GR_W{1'b0}};
    end else if (grav_cnt_r == GR_LAST) begin
      grav_cnt_r <= {GR_W{1'b0}};
    end else begin
      grav_cnt_r <= grav_cnt_r + {{(GR_W-1){1'b0}}, 1'b1};
    end
  end
`else
  assign grav_tick_s = 1'b0;
`endif

  // Rotate on the debounced S1 press edge; an edge landing in game_over is consumed
  always_ff @(posedge clk) begin
    if (reset) begin
      rot_prev_r  <= 1'b0;
      rotate_r    <= 1'b0;
      move_down_r <= 1'b0;
    end else begin
      rot_prev_r  <= pressed_r[0];
      rotate_r    <= pressed_r[0] && !rot_prev_r && !io.game_over;
      move_down_r <= s_fire_s || grav_tick_s;
    end
  end

  assign io.move_left   = move_left_r;
  assign io.move_right  = move_right_r;
  assign io.move_down   = move_down_r;
  assign io.rotate      = rotate_r;
  assign io.tilt_active = tilt_active_r;

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Scoreboard bench for tetris_input_ctrl: a rule-level model queues expected pulses,
// a negedge monitor pops and compares them. Define TETRIS_GRAVITY_EN to cover gravity.
module tb_tetris_input_ctrl;
  localparam int DEB  = 4;
  localparam int DAS  = 10;
  localparam int ARR  = 3;
  localparam int GRAV = 50;

  typedef struct {
    int         cyc;
    logic [3:0] vec;  // {rotate, move_down, move_right, move_left}
  } evt_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  tetris_input_ctrl_if io ();

  tetris_input_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .DAS_CYCLES     (DAS),
    .ARR_CYCLES     (ARR),
    .GRAVITY_CYCLES (GRAV)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .io   (io)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  evt_t sb[$];

  // Reference model state: tilt zone, age of each active repeat input, button history.
  int cyc = 0;
  int adc_q = 0;
  int tilt = 0;        // 0 centre, 1 left, 2 right
  int h_age = 0;
  int h_dir = 0;
  bit h_was = 1'b0;
  int s_age = 0;
  bit s_was = 1'b0;
  int g_cnt = 0;
  bit tilt_exp = 1'b0;
  bit rot_d = 1'b0;
  bit d1 [2];
  bit d2 [2];
  bit db [2];
  bit hist [2][DEB];

  function automatic int tilt_next(input int t, input int a);
    case (t)
      0:       return (a > 1820) ? 2 : ((a < 1480) ? 1 : 0);
      2:       return (a < 1480) ? 1 : ((a < 1780) ? 0 : 2);
      default: return (a > 1820) ? 2 : ((a > 1520) ? 0 : 1);
    endcase
  endfunction

  // Pulse on activation, after DAS cycles, then every ARR cycles.
  function automatic bit rpt_fire(input int age);
    return (age == 0) || (age >= DAS && ((age - DAS) % ARR) == 0);
  endfunction

  always @(posedge clk) begin
    evt_t e;
    bit   h_act, s_act, h_p, s_p, g_p, rot_p, all_diff;
    int   dir;
    cyc++;
    if (reset) begin
      adc_q = 0; tilt = 0; h_age = 0; h_dir = 0; h_was = 1'b0;
      s_age = 0; s_was = 1'b0; g_cnt = 0; tilt_exp = 1'b0; rot_d = 1'b0;
      for (int b = 0; b < 2; b++) begin
        d1[b] = 1'b0; d2[b] = 1'b0; db[b] = 1'b0;
        for (int k = 0; k < DEB; k++) hist[b][k] = 1'b0;
      end
    end else begin
      dir   = tilt;
      h_act = (tilt != 0) && !io.game_over;
      if (h_act) begin
        h_age = (h_was && dir == h_dir) ? h_age + 1 : 0;
        h_dir = dir;
      end
      h_was = h_act;
      h_p   = h_act && rpt_fire(h_age);

      s_act = db[1] && !io.game_over;
      if (s_act) s_age = s_was ? s_age + 1 : 0;
      s_was = s_act;
      s_p   = s_act && rpt_fire(s_age);

      rot_p = db[0] && !rot_d && !io.game_over;
      rot_d = db[0];
`ifdef TETRIS_GRAVITY_EN
      if (io.game_over) g_cnt = 0;
      else g_cnt++;
      g_p = !io.game_over && (g_cnt % GRAV) == 0;
`else
      g_p = 1'b0;
`endif
      tilt_exp = (tilt != 0);
      tilt     = tilt_next(tilt, adc_q);
      adc_q    = int'(io.adc_value);

      // A button flips once its last DEB synchronized samples all disagree with it.
      for (int b = 0; b < 2; b++) begin
        for (int k = DEB - 1; k > 0; k--) hist[b][k] = hist[b][k-1];
        hist[b][0] = d2[b];
        all_diff = 1'b1;
        for (int k = 0; k < DEB; k++) if (hist[b][k] == db[b]) all_diff = 1'b0;
        if (all_diff) db[b] = !db[b];
        d2[b] = d1[b];
      end
      d1[0] = !io.s1_n;
      d1[1] = !io.s2_n;

      e.cyc = cyc;
      e.vec = {rot_p, s_p || g_p, h_p && dir == 2, h_p && dir == 1};
      if (e.vec != 4'b0000) sb.push_back(e);
    end
  end

  // Monitor: pops expected pulses as the DUT presents them; also tracks tilt_active.
  always @(negedge clk) begin
    logic [3:0] dv;
    if (cyc > 0) begin
      dv = {io.rotate, io.move_down, io.move_right, io.move_left};
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL missed_pulse cyc=%0d got=0000 expected=%b", sb[0].cyc, sb[0].vec);
        sb.delete(0);
      end
      if (dv !== 4'b0000) begin
        checks++;
        if (sb.size() == 0 || sb[0].cyc != cyc || sb[0].vec !== dv) begin
          errors++;
          $display("FAIL pulse cyc=%0d got=%b expected=%b", cyc, dv,
                   (sb.size() > 0 && sb[0].cyc == cyc) ? sb[0].vec : 4'b0000);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) sb.delete(0);
      end
      checks++;
      if (io.tilt_active !== tilt_exp) begin
        errors++;
        $display("FAIL tilt_active cyc=%0d got=%b expected=%b", cyc, io.tilt_active, tilt_exp);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  int hyst_adc [5] = '{1830, 1800, 1770, 1490, 1470};
  int hyst_exp [5] = '{1, 1, 0, 0, 1};
  int thr [12] = '{1479, 1480, 1481, 1519, 1520, 1521, 1779, 1780, 1781, 1819, 1820, 1821};

  initial begin
    int first, nrot, nr, nl, nany, r;
    io.s1_n = 1'b0; io.s2_n = 1'b1; io.adc_value = 12'd2000; io.game_over = 1'b0;
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;

    // Right tilt and a held S1 both survive reset as fresh events.
    first = 0; nrot = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (io.move_right === 1'b1 && first == 0) first = i;
      if (io.rotate === 1'b1) nrot++;
    end
    check_int("reset_first_right", first, 3);
    check_int("reset_rotate_count", nrot, 1);
    io.s1_n = 1'b1; io.adc_value = 12'd1650;
    wait_cyc(30);

    // Short glitch rejected; long press gives one rotate, none on release.
    io.s1_n = 1'b0; wait_cyc(3); io.s1_n = 1'b1;
    nrot = 0;
    repeat (20) begin @(negedge clk); if (io.rotate === 1'b1) nrot++; end
    check_int("glitch_rotate", nrot, 0);
    io.s1_n = 1'b0; first = 0; nrot = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (io.rotate === 1'b1) begin nrot++; if (first == 0) first = i; end
    end
    check_int("press_rotate_latency", first, 7);
    check_int("press_rotate_count", nrot, 1);
    io.s1_n = 1'b1; nrot = 0;
    repeat (20) begin @(negedge clk); if (io.rotate === 1'b1) nrot++; end
    check_int("release_rotate", nrot, 0);

    // Auto-repeat: T, T+10, T+13 ... T+28.
    io.adc_value = 12'd2000; nr = 0; nl = 0;
    repeat (31) begin
      @(negedge clk);
      if (io.move_right === 1'b1) nr++;
      if (io.move_left === 1'b1) nl++;
    end
    check_int("das_arr_right_count", nr, 8);
    check_int("das_arr_left_count", nl, 0);
    io.adc_value = 12'd1650; wait_cyc(20);

    // Hysteresis walk.
    for (int i = 0; i < 5; i++) begin
      io.adc_value = 12'(hyst_adc[i]);
      wait_cyc(20);
      check_int("hysteresis_tilt", int'(io.tilt_active), hyst_exp[i]);
    end

    // Reversal, then game_over masking and release.
    io.adc_value = 12'd2000; wait_cyc(15);
    io.adc_value = 12'd1000; first = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (io.move_left === 1'b1 && first == 0) first = i;
    end
    check_int("reversal_left_latency", first, 3);
    io.game_over = 1'b1; nany = 0;
    repeat (20) begin
      @(negedge clk);
      if ({io.rotate, io.move_down, io.move_right, io.move_left} !== 4'b0000) nany++;
    end
    check_int("game_over_pulses", nany, 0);
    io.game_over = 1'b0;
    @(negedge clk);
    check_int("game_over_release_left", int'(io.move_left), 1);
    wait_cyc(20);

    // Idle (gravity only when enabled), then held soft drop.
    io.adc_value = 12'd1650; wait_cyc(120);
    io.s2_n = 1'b0; wait_cyc(200);
    io.s2_n = 1'b1; wait_cyc(20);

    // Randomized mix around the thresholds with buttons, game_over and resets.
    for (int seg = 0; seg < 250; seg++) begin
      r = $urandom_range(0, 15);
      if (r < 6)       io.adc_value = 12'(thr[$urandom_range(0, 11)]);
      else if (r < 8)  io.adc_value = 12'($urandom_range(0, 4095));
      else if (r < 11) io.s1_n = ~io.s1_n;
      else if (r < 14) io.s2_n = ~io.s2_n;
      else if (r == 14) io.game_over = ~io.game_over;
      else begin
        reset = 1'b1; wait_cyc($urandom_range(1, 2)); reset = 1'b0;
      end
      wait_cyc($urandom_range(1, 25));
    end

    reset = 1'b0; io.game_over = 1'b0; io.s2_n = 1'b1;
    wait_cyc(30);
    check_int("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
